// File: rtl/mult_pkg.sv
// Shared helpers for the tree multiplier: product width, Baugh-Wooley
// correction constant and reduction-tree depth.
package mult_pkg;

    localparam int MAX_W = 64;

    function automatic int prod_w(input int w);
        return 2 * w;
    endfunction

    // Rows left after k levels of 3:2 compression (groups of three become two).
    function automatic int rows_after(input int rows, input int k);
        int r;
        r = rows;
        for (int i = 0; i < k; i++) r = 2 * (r / 3) + r % 3;
        return r;
    endfunction

    function automatic int tree_stages(input int rows);
        int r;
        int s;
        r = rows;
        s = 0;
        while (r > 2) begin
            r = 2 * (r / 3) + r % 3;
            s++;
        end
        return s;
    endfunction

    // Inverting the sign-row/sign-column partial products leaves a deficit
    // that is repaid by ones at bit w and bit 2w-1 (mod 2^(2w)).
    function automatic logic [2*MAX_W-1:0] bw_corr(input int w);
        logic [2*MAX_W-1:0] one;
        one = 1;
        return (one << w) | (one << (2 * w - 1));
    endfunction

    localparam int MAX_TREE_STAGES = tree_stages(MAX_W + 1);

endpackage

// File: rtl/prefix_adder.sv
// Combinational Kogge-Stone adder built from generate/propagate cells.
// Sum only; the carry out of the top bit is dropped.
module prefix_adder #(
    parameter int N = 16
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] sum
);

    localparam int L = (N > 1) ? $clog2(N) : 1;

    logic [L:0][N-1:0] g;
    logic [L:0][N-1:0] p;
    logic [N:0]        unused_top;

    assign g[0] = a & b;
    assign p[0] = a ^ b;

    for (genvar l = 0; l < L; l++) begin : g_lvl
        for (genvar i = 0; i < N; i++) begin : g_bit
            if (i >= (1 << l)) begin : g_cell
                assign g[l+1][i] = g[l][i] | (p[l][i] & g[l][i-(1<<l)]);
                assign p[l+1][i] = p[l][i] & p[l][i-(1<<l)];
            end else begin : g_pass
                assign g[l+1][i] = g[l][i];
                assign p[l+1][i] = p[l][i];
            end
        end
    end

    if (N > 1) begin : g_sum
        assign sum = p[0] ^ {g[L][N-2:0], 1'b0};
    end else begin : g_sum1
        assign sum = p[0];
    end

    assign unused_top = {g[L][N-1], p[L]};

endmodule

// File: rtl/pipelined_tree_multiplier.sv
// Two-stage WIDTH x WIDTH multiplier: S1 reduces the partial products to two
// rows, S2 adds them with a prefix adder. Valid/ready on both sides.
module pipelined_tree_multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int TAG_W = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_a,
    input  logic [WIDTH-1:0]           in_b,
    input  logic                       in_signed,
    input  logic [TAG_W-1:0]           in_tag,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [prod_w(WIDTH)-1:0]   out_product,
    output logic [TAG_W-1:0]           out_tag
);

    localparam int P      = prod_w(WIDTH);
    localparam int NROWS  = WIDTH + 1;
    localparam int STAGES = tree_stages(NROWS);
    localparam logic [P-1:0] CORR = P'(bw_corr(WIDTH));

    typedef struct packed {
        logic [P-1:0]     sum;
        logic [P-1:0]     carry;
        logic [TAG_W-1:0] tag;
    } s1_t;

    logic [P-1:0] lvl [STAGES+1][NROWS];
    logic [2:1]   vld_pipe;
    logic         adv1;
    logic         adv2;
    s1_t          s1_q;
    logic [P-1:0] sum2;
    logic [P-1:0] prod_q;
    logic [TAG_W-1:0] tag_q;

    // Partial-product rows; signed mode inverts the bits where exactly one
    // operand index is the sign bit, and the last row carries the correction.
    for (genvar i = 0; i < WIDTH; i++) begin : g_pp
        logic [WIDTH-1:0] bits;
        for (genvar j = 0; j < WIDTH; j++) begin : g_bit
            localparam bit INV = ((i == WIDTH - 1) != (j == WIDTH - 1));
            assign bits[j] = (in_a[j] & in_b[i]) ^ (INV & in_signed);
        end
        assign lvl[0][i] = {{WIDTH{1'b0}}, bits} << i;
    end
    assign lvl[0][WIDTH] = in_signed ? CORR : '0;

    // Each level packs groups of three rows into sum/carry pairs at the front,
    // leftovers slide in behind them, unused slots are zero.
    for (genvar k = 0; k < STAGES; k++) begin : g_tree
        localparam int RK = rows_after(NROWS, k);
        localparam int NG = RK / 3;
        for (genvar r = 0; r < NROWS; r++) begin : g_row
            if (r < 2 * NG) begin : g_csa
                localparam int B = 3 * (r / 2);
                if (r % 2 == 0) begin : g_s
                    assign lvl[k+1][r] = lvl[k][B] ^ lvl[k][B+1] ^ lvl[k][B+2];
                end else begin : g_c
                    assign lvl[k+1][r] = ((lvl[k][B] & lvl[k][B+1]) |
                                          (lvl[k][B] & lvl[k][B+2]) |
                                          (lvl[k][B+1] & lvl[k][B+2])) << 1;
                end
            end else if (r < 2 * NG + RK % 3) begin : g_pass
                assign lvl[k+1][r] = lvl[k][r+NG];
            end else begin : g_zero
                assign lvl[k+1][r] = '0;
            end
        end
    end

    assign adv2     = !vld_pipe[2] | out_ready;
    assign adv1     = !vld_pipe[1] | adv2;
    assign in_ready = adv1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            s1_q     <= '0;
            prod_q   <= '0;
            tag_q    <= '0;
        end else begin
            if (adv1) vld_pipe[1] <= in_valid;
            if (adv2) vld_pipe[2] <= vld_pipe[1];
            if (in_valid && adv1)
                s1_q <= s1_t'{sum: lvl[STAGES][0], carry: lvl[STAGES][1], tag: in_tag};
            if (adv2 && vld_pipe[1]) begin
                prod_q <= sum2;
                tag_q  <= s1_q.tag;
            end
        end
    end

    prefix_adder #(.N(P)) u_add (
        .a   (s1_q.sum),
        .b   (s1_q.carry),
        .sum (sum2)
    );

    assign out_valid   = vld_pipe[2];
    assign out_product = prod_q;
    assign out_tag     = tag_q;

endmodule

// File: tb/tb_pipelined_tree_multiplier.sv
// Bench for pipelined_tree_multiplier: WIDTH=8 and WIDTH=4 instances side by
// side, directed table, backpressure/reset sequences, random and exhaustive runs.
module tb_pipelined_tree_multiplier;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        v8 = 0, ordy8 = 1, s8 = 0;
    logic [7:0]  a8 = 0, b8 = 0;
    logic [3:0]  t8 = 0;
    logic        ir8, ov8;
    logic [15:0] p8;
    logic [3:0]  ot8;

    logic        v4 = 0, ordy4 = 1, s4 = 0;
    logic [3:0]  a4 = 0, b4 = 0;
    logic [3:0]  t4 = 0;
    logic        ir4, ov4;
    logic [7:0]  p4;
    logic [3:0]  ot4;

    pipelined_tree_multiplier #(.WIDTH(8), .TAG_W(4)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(ir8), .in_a(a8), .in_b(b8),
        .in_signed(s8), .in_tag(t8), .out_valid(ov8), .out_ready(ordy8),
        .out_product(p8), .out_tag(ot8));

    pipelined_tree_multiplier #(.WIDTH(4), .TAG_W(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(v4), .in_ready(ir4), .in_a(a4), .in_b(b4),
        .in_signed(s4), .in_tag(t4), .out_valid(ov4), .out_ready(ordy4),
        .out_product(p4), .out_tag(ot4));

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct packed {
        logic [15:0] p;
        logic [3:0]  t;
    } exp_t;
    exp_t q8[$];
    exp_t q4[$];

    typedef struct {
        bit          w4;
        logic [7:0]  a;
        logic [7:0]  b;
        bit          s;
        logic [3:0]  t;
        logic [15:0] exp;
    } vec_t;
    vec_t tbl[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Product from plain integer arithmetic on the interpreted operands.
    function automatic logic [15:0] model(input int w, input logic [7:0] a,
                                          input logic [7:0] b, input bit s);
        int ia, ib, pr;
        ia = int'(a) & ((1 << w) - 1);
        ib = int'(b) & ((1 << w) - 1);
        if (s && ia >= (1 << (w - 1))) ia -= (1 << w);
        if (s && ib >= (1 << (w - 1))) ib -= (1 << w);
        pr = ia * ib;
        return 16'(pr & ((1 << (2 * w)) - 1));
    endfunction

    // Scoreboard: every accepted op is expected back in order, exactly once.
    always @(negedge clk) begin
        if (rst_n) begin
            if (ov8 && ordy8) begin
                check("dut8 result expected", 32'(q8.size() > 0), 1);
                if (q8.size() > 0) begin
                    exp_t e;
                    e = q8.pop_front();
                    check("dut8 product", 32'(p8), 32'(e.p));
                    check("dut8 tag", 32'(ot8), 32'(e.t));
                end
            end
            if (v8 && ir8) q8.push_back('{model(8, a8, b8, s8), t8});
            if (ov4 && ordy4) begin
                check("dut4 result expected", 32'(q4.size() > 0), 1);
                if (q4.size() > 0) begin
                    exp_t e;
                    e = q4.pop_front();
                    check("dut4 product", 32'(p4), 32'(e.p));
                    check("dut4 tag", 32'(ot4), 32'(e.t));
                end
            end
            if (v4 && ir4) q4.push_back('{model(4, {4'b0, a4}, {4'b0, b4}, s4), t4});
        end
    end

    always @(negedge rst_n) begin
        q8.delete();
        q4.delete();
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single op on an idle pipe: out_valid must be low one edge after
    // acceptance and high with the right result after the second.
    task automatic run_vec(input vec_t v);
        if (v.w4) begin
            a4 = v.a[3:0]; b4 = v.b[3:0]; s4 = v.s; t4 = v.t; v4 = 1; ordy4 = 1;
        end else begin
            a8 = v.a; b8 = v.b; s8 = v.s; t8 = v.t; v8 = 1; ordy8 = 1;
        end
        tick();
        v4 = 0; v8 = 0;
        @(negedge clk);
        check("latency early valid", 32'(v.w4 ? ov4 : ov8), 0);
        tick();
        @(negedge clk);
        check("latency valid", 32'(v.w4 ? ov4 : ov8), 1);
        check("vec product", v.w4 ? 32'(p4) : 32'(p8), 32'(v.exp));
        check("vec tag", 32'(v.w4 ? ot4 : ot8), 32'(v.t));
        tick();
    endtask

    task automatic send(input bit w4, input logic [7:0] a, input logic [7:0] b,
                        input bit s, input logic [3:0] t);
        int guard;
        bit acc;
        guard = 0;
        acc = 0;
        if (w4) begin a4 = a[3:0]; b4 = b[3:0]; s4 = s; t4 = t; v4 = 1; end
        else begin a8 = a; b8 = b; s8 = s; t8 = t; v8 = 1; end
        do begin
            if (w4) ordy4 = ($urandom_range(0, 3) != 0);
            else    ordy8 = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            acc = w4 ? ir4 : ir8;
            tick();
            guard++;
        end while (!acc && guard < 50);
        check("send accepted", 32'(acc), 1);
        v4 = 0; v8 = 0;
    endtask

    initial begin
        logic [15:0] exp0;
        int cnt, first, last;

        tbl[0]  = '{0, 8'h80, 8'h80, 1, 4'd1,  16'h4000};
        tbl[1]  = '{0, 8'hFF, 8'h01, 1, 4'd2,  16'hFFFF};
        tbl[2]  = '{0, 8'h7F, 8'h80, 1, 4'd3,  16'hC080};
        tbl[3]  = '{0, 8'hFF, 8'hFF, 0, 4'd4,  16'hFE01};
        tbl[4]  = '{0, 8'hFF, 8'hFF, 1, 4'd5,  16'h0001};
        tbl[5]  = '{0, 8'h80, 8'h01, 1, 4'd6,  16'hFF80};
        tbl[6]  = '{0, 8'h80, 8'h01, 0, 4'd7,  16'h0080};
        tbl[7]  = '{0, 8'h7F, 8'h7F, 1, 4'd8,  16'h3F01};
        tbl[8]  = '{0, 8'h00, 8'hA5, 1, 4'd9,  16'h0000};
        tbl[9]  = '{1, 8'h0F, 8'h0F, 0, 4'd3,  16'h00E1};
        tbl[10] = '{1, 8'h0F, 8'h0F, 1, 4'd10, 16'h0001};
        tbl[11] = '{1, 8'h08, 8'h08, 1, 4'd11, 16'h0040};
        tbl[12] = '{1, 8'h07, 8'h08, 1, 4'd12, 16'h00C8};

        #3;
        check("reset out_valid8", 32'(ov8), 0);
        check("reset product8", 32'(p8), 0);
        check("reset tag8", 32'(ot8), 0);
        check("reset out_valid4", 32'(ov4), 0);
        tick(); tick();
        #1 rst_n = 1;
        #1;
        check("in_ready after reset8", 32'(ir8), 1);
        check("in_ready after reset4", 32'(ir4), 1);
        tick();

        foreach (tbl[i]) run_vec(tbl[i]);

        // Backpressure: four tagged ops against a stalled consumer.
        ordy8 = 0;
        a8 = 8'($urandom); b8 = 8'($urandom); s8 = 1; t8 = 0; v8 = 1;
        exp0 = model(8, a8, b8, s8);
        @(negedge clk); check("bp accept0 ready", 32'(ir8), 1);
        tick();
        a8 = 8'($urandom); b8 = 8'($urandom); s8 = 0; t8 = 1;
        @(negedge clk); check("bp accept1 ready", 32'(ir8), 1);
        tick();
        a8 = 8'($urandom); b8 = 8'($urandom); s8 = 1; t8 = 2;
        @(negedge clk);
        check("bp full in_ready", 32'(ir8), 0);
        check("bp hold tag", 32'(ot8), 0);
        check("bp hold product", 32'(p8), 32'(exp0));
        for (int c = 0; c < 5; c++) begin
            tick();
            @(negedge clk);
            check("bp stall in_ready", 32'(ir8), 0);
            check("bp stall valid", 32'(ov8), 1);
            check("bp stall tag", 32'(ot8), 0);
            check("bp stall product", 32'(p8), 32'(exp0));
        end
        tick();
        ordy8 = 1;
        @(negedge clk);
        check("bp release in_ready", 32'(ir8), 1);
        check("bp order tag0", 32'(ot8), 0);
        tick();
        a8 = 8'($urandom); b8 = 8'($urandom); s8 = 0; t8 = 3;
        @(negedge clk); check("bp order tag1", 32'({ov8, ot8}), 32'({1'b1, 4'd1}));
        tick();
        v8 = 0;
        @(negedge clk); check("bp order tag2", 32'({ov8, ot8}), 32'({1'b1, 4'd2}));
        tick();
        @(negedge clk); check("bp order tag3", 32'({ov8, ot8}), 32'({1'b1, 4'd3}));
        tick();
        @(negedge clk); check("bp drained", 32'(ov8), 0);
        tick();

        // Streaming at full rate, alternating mode.
        ordy8 = 1;
        cnt = 0; first = -1; last = -1;
        for (int c = 0; c < 24; c++) begin
            if (c < 20) begin
                a8 = 8'($urandom); b8 = 8'($urandom); s8 = c[0]; t8 = 4'(c); v8 = 1;
            end else v8 = 0;
            @(negedge clk);
            if (c < 20) check("stream in_ready", 32'(ir8), 1);
            if (ov8) begin
                cnt++;
                if (first < 0) first = c;
                last = c;
            end
            tick();
        end
        check("stream count", 32'(cnt), 20);
        check("stream first", 32'(first), 2);
        check("stream contiguous", 32'(last - first), 19);

        // Asynchronous reset with both stages full.
        ordy8 = 0;
        a8 = 8'($urandom); b8 = 8'($urandom); s8 = 1; t8 = 4'd5; v8 = 1;
        tick();
        a8 = 8'($urandom); t8 = 4'd6;
        tick();
        v8 = 0;
        #1;
        check("pre-reset valid", 32'(ov8), 1);
        rst_n = 0;
        #1;
        check("async reset valid", 32'(ov8), 0);
        check("async reset product", 32'(p8), 0);
        check("async reset tag", 32'(ot8), 0);
        tick(); tick();
        #1 rst_n = 1;
        #1;
        check("post-reset in_ready", 32'(ir8), 1);
        tick();
        ordy8 = 1;
        run_vec(tbl[0]);

        // Random ops with random consumer readiness.
        for (int i = 0; i < 150; i++)
            send(0, 8'($urandom), 8'($urandom), bit'($urandom_range(0, 1)), 4'($urandom));
        ordy8 = 1;

        // Exhaustive WIDTH=4 in both modes.
        for (int i = 0; i < 512; i++)
            send(1, 8'(i[3:0]), 8'(i[7:4]), i[8], 4'(i));
        ordy4 = 1;

        repeat (6) tick();
        check("dut8 scoreboard empty", 32'(q8.size()), 0);
        check("dut4 scoreboard empty", 32'(q4.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
